accum_mem_arbiter: RTL
======================

Name: accum_mem_arbiter

Overview:
- Shares the single data-memory port between the processor (requester P) and the accumulation accelerator (requester X).
- Each cycle it grants at most one val/rdy request, using round-robin priority.
- It records the owner of every in-flight request in an in-order tracking FIFO, and steers each memory response back to that owner.
- Sits between the processor/accelerator memory interfaces and the memory port.

Parameters:
- MAX_OUT, 4, maximum outstanding (requested, not yet responded) transactions; power of two, ≥2.
- DATA_W, 32, width of address, write data and read data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- p_req_val  in  1  processor request valid
- p_req_rdy  out  1  processor request accepted
- p_req_type  in  1  0=read, 1=write
- p_req_addr  in  DATA_W  processor byte address
- p_req_data  in  DATA_W  processor write data
- p_resp_val  out  1  response valid to processor
- p_resp_rdy  in  1  processor can take response
- p_resp_data  out  DATA_W  read data to processor (0 for writes)
- x_req_val, x_req_rdy, x_req_type, x_req_addr, x_req_data: same as p_* for the accelerator
- x_resp_val, x_resp_rdy, x_resp_data: same as p_resp_* for the accelerator
- memreq_val  out  1  request to memory
- memreq_rdy  in  1  memory accepts request
- memreq_type  out  1  forwarded type
- memreq_addr  out  DATA_W  forwarded address
- memreq_data  out  DATA_W  forwarded write data
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  arbiter takes response
- memresp_data  in  DATA_W  memory read data

Behaviour:
- Handshake: a transfer occurs in any cycle where val&&rdy; no other cycle transfers. Memory returns responses in request order.
- State:
  - prio bit: 0 = P preferred, 1 = X preferred.
  - Tracking FIFO: MAX_OUT entries × 1-bit owner (0=P, 1=X), with head/tail pointers and a count register of width clog2(MAX_OUT)+1.
- Reset:
  - prio=0, FIFO empty (count=0, pointers 0).
  - All val/rdy outputs 0 in the reset cycle; data outputs don't-care but driven 0.
- Grant (combinational within cycle):
  - Requests are considered only when count<MAX_OUT and not rst.
  - If only one requester is valid, it wins.
  - If both are valid, the one indicated by prio wins.
  - memreq_* carries the winner's fields, with memreq_val=1.
  - winner_req_rdy = memreq_rdy; loser_req_rdy = 0.
  - When FIFO is full, both req_rdy=0 and memreq_val=0.
- On request transfer: push the winner's ID at tail; prio ← ~winner. prio does not change on cycles without a transfer. A winner that is not accepted (memreq_rdy=0) keeps the grant only if its val persists; re-arbitration is allowed each cycle.
- Response routing:
  - When count>0, owner=FIFO[head].
  - owner_resp_val = memresp_val; other_resp_val = 0.
  - Both resp_data = memresp_data.
  - memresp_rdy = owner's resp_rdy.
- On response transfer: pop head.
- Empty FIFO with memresp_val=1: memresp_rdy=0 and both resp_val=0; the response is held off, never dropped or misrouted.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Pointers wrap modulo MAX_OUT.
- Full FIFO with a pop in the same cycle: no push that cycle, because grant is gated on registered count. This avoids a rdy-to-rdy combinational loop.
- Latency: zero-cycle pass-through both directions; no request or response buffering inside the block.
- Reset mid-operation: FIFO cleared and prio=0 on the next edge. Outstanding responses are abandoned; the environment must reset memory together with the arbiter.

Decomposition:
- Shared package: owner ID localparams (OWNER_P=0, OWNER_X=1), request type constants (REQ_READ=0, REQ_WRITE=1).
- One sub-module: arb_owner_fifo (MAX_OUT-deep, 1-bit wide, synchronous reset, push/pop/full/empty/head outputs).
- Arbitration and routing live in the top-level.

Test Plan:
- Reset, then idle with no valids → all val/rdy outputs 0, FIFO empty for 5 cycles.
- P read addr 0x100 only, memreq_rdy=1; memory returns 0xDEAD one cycle later → memreq_addr=0x100, p_resp_val=1, p_resp_data=0xDEAD, x_resp_val=0.
- P and X both valid every cycle for 4 accepted requests, memreq_rdy=1 → grant order P,X,P,X; responses 1..4 delivered to P,X,P,X in order.
- Memory stalls responses, both requesters hammer requests → exactly 4 accepted, then req_rdy=0 on both until the first response pops; the next grant goes to the requester indicated by prio.
- Response for X arrives with x_resp_rdy=0 for 3 cycles → memresp_rdy=0 for 3 cycles, delivered on cycle 4, count decrements once.
- memresp_val=1 while FIFO empty → memresp_rdy=0, no resp_val; then assert rst mid-traffic with 2 outstanding → count=0, prio=0 next cycle.

Source files
------------

// File: rtl/accum_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// accum_mem_arbiter_pkg : owner IDs, request types and grant helper
// Revision: 1.0
// ============================================================================
package accum_mem_arbiter_pkg;

  localparam logic OWNER_P   = 1'b0;
  localparam logic OWNER_X   = 1'b1;
  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Contended cycles follow prio; otherwise the sole valid requester wins.
  function automatic logic pick_owner(input logic p_val, input logic x_val,
                                      input logic prio);
    return (p_val && x_val) ? prio : (x_val ? OWNER_X : OWNER_P);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_owner_fifo.sv
`default_nettype none
// ============================================================================
// arb_owner_fifo : in-order 1-bit owner tracking FIFO for in-flight requests
// Revision: 1.0
// ============================================================================
module arb_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_head];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_tail] <= i_push_id;
        r_tail        <= r_tail + AW'(1);
      end
      if (w_pop_ok) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/accum_mem_arbiter.sv
`default_nettype none
// ============================================================================
// accum_mem_arbiter : round-robin share of one memory port between P and X
// Revision: 1.0
// ============================================================================
module accum_mem_arbiter
  import accum_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req_val,
  output logic              p_req_rdy,
  input  logic              p_req_type,
  input  logic [DATA_W-1:0] p_req_addr,
  input  logic [DATA_W-1:0] p_req_data,
  output logic              p_resp_val,
  input  logic              p_resp_rdy,
  output logic [DATA_W-1:0] p_resp_data,
  input  logic              x_req_val,
  output logic              x_req_rdy,
  input  logic              x_req_type,
  input  logic [DATA_W-1:0] x_req_addr,
  input  logic [DATA_W-1:0] x_req_data,
  output logic              x_resp_val,
  input  logic              x_resp_rdy,
  output logic [DATA_W-1:0] x_resp_data,
  output logic              memreq_val,
  input  logic              memreq_rdy,
  output logic              memreq_type,
  output logic [DATA_W-1:0] memreq_addr,
  output logic [DATA_W-1:0] memreq_data,
  input  logic              memresp_val,
  output logic              memresp_rdy,
  input  logic [DATA_W-1:0] memresp_data
);

  logic r_prio;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_can_req;
  logic w_winner;
  logic w_push;
  logic w_has_owner;
  logic w_pop;

  // Gating on the registered full flag keeps req_rdy independent of resp_rdy.
  assign w_can_req = !rst && !w_full;
  assign w_winner  = pick_owner(p_req_val, x_req_val, r_prio);
  assign memreq_val  = w_can_req && (p_req_val || x_req_val);
  assign memreq_type = memreq_val && ((w_winner == OWNER_X) ? x_req_type : p_req_type);
  assign memreq_addr = !memreq_val ? '0 : ((w_winner == OWNER_X) ? x_req_addr : p_req_addr);
  assign memreq_data = !memreq_val ? '0 : ((w_winner == OWNER_X) ? x_req_data : p_req_data);
  assign p_req_rdy   = memreq_val && (w_winner == OWNER_P) && memreq_rdy;
  assign x_req_rdy   = memreq_val && (w_winner == OWNER_X) && memreq_rdy;
  assign w_push      = memreq_val && memreq_rdy;

  // With nothing outstanding, a memory response is held off rather than routed.
  assign w_has_owner = !rst && !w_empty;
  assign p_resp_val  = w_has_owner && (w_head == OWNER_P) && memresp_val;
  assign x_resp_val  = w_has_owner && (w_head == OWNER_X) && memresp_val;
  assign memresp_rdy = w_has_owner && ((w_head == OWNER_X) ? x_resp_rdy : p_resp_rdy);
  assign p_resp_data = rst ? '0 : memresp_data;
  assign x_resp_data = rst ? '0 : memresp_data;
  assign w_pop       = memresp_val && memresp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= OWNER_P;
    end else if (w_push) begin
      r_prio <= ~w_winner;
    end
  end

  arb_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (w_winner),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule
`default_nettype wire
